axil_uart_tx_responder: RTL and testbench

//  AXI4-Lite responder for the processor's peripheral bus (13-bit address window) that implements the UART transmit side.
//  Bus writes to TX_DATA push bytes into a TX FIFO; a serializer drives 8N1 frames on sout.
//  A status register reports FIFO and line state.

---
 rtl/uart_periph_pkg.sv | 23 ++
 rtl/uart_tx_fifo.sv | 47 ++++
 rtl/axil_uart_tx_responder.sv | 225 ++++++++++++++++++++++
 tb/tb_axil_uart_tx_responder.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_periph_pkg.sv
// Shared register offsets, AXI response codes and serializer state encoding
// for the UART transmit peripheral.
package uart_periph_pkg;

    localparam logic [31:0] TX_DATA_OFF = 32'h0000_1000;
    localparam logic [31:0] STATUS_OFF  = 32'h0000_1004;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } uart_tx_state_t;

    function automatic logic [31:0] status_word(input logic full, input logic empty,
                                                input logic idle);
        return {29'd0, idle, empty, full};
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART serializer; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    input  logic       pop_i,
    output logic [7:0] pop_data_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic [7:0]  mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/axil_uart_tx_responder.sv
// AXI4-Lite slave exposing a UART transmitter: TX_DATA pushes bytes into a
// FIFO, STATUS reports FIFO/line state, and an 8N1 serializer drives sout.
//
//  state    | meaning
//  TX_IDLE  | line high, pops the next byte when the FIFO has one
//  TX_START | start bit (sout=0) for CLKS_PER_BIT cycles
//  TX_DATA  | 8 data bits LSB first, CLKS_PER_BIT cycles each
//  TX_STOP  | stop bit (sout=1) for CLKS_PER_BIT cycles
module axil_uart_tx_responder
    import uart_periph_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_W       = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
    output logic              sout
);

    localparam logic [ADDR_W-1:0] TX_OFF  = ADDR_W'(TX_DATA_OFF);
    localparam logic [ADDR_W-1:0] STS_OFF = ADDR_W'(STATUS_OFF);
    localparam logic [15:0]       BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    logic              aw_held_q;
    logic [ADDR_W-1:0] aw_addr_q;
    logic              w_held_q;
    logic [7:0]        w_data_q;
    logic              w_strb0_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;
    logic              rvalid_q;
    logic [31:0]       rdata_q;
    logic [1:0]        rresp_q;

    uart_tx_state_t    state_q, state_d;
    logic [15:0]       baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_rdata;
    logic              fifo_pop;
    logic              fifo_push;
    logic              aw_is_tx;
    logic              aw_is_sts;
    logic              push_req;
    logic              wr_commit;
    logic              tx_idle;
    logic              baud_done;
    logic              unused_wr_bits;

    assign unused_wr_bits = ^{wdata[31:8], wstrb[3:1]};

    assign awready = !aw_held_q;
    assign wready  = !w_held_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = !rvalid_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

    assign aw_is_tx  = (aw_addr_q == TX_OFF);
    assign aw_is_sts = (aw_addr_q == STS_OFF);
    assign push_req  = aw_is_tx && w_strb0_q;
    assign fifo_pop  = (state_q == TX_IDLE) && !fifo_empty;

    // A push into a full FIFO stalls the B response unless a pop frees a slot now.
    assign wr_commit = aw_held_q && w_held_q && !bvalid_q &&
                       (!push_req || !fifo_full || fifo_pop);
    assign fifo_push = wr_commit && push_req;

    assign tx_idle   = fifo_empty && (state_q == TX_IDLE);

    uart_tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fifo_push),
        .push_data_i(w_data_q),
        .pop_i      (fifo_pop),
        .pop_data_o (fifo_rdata),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held_q <= 1'b0;
            aw_addr_q <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb0_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (awvalid && awready) begin
                aw_held_q <= 1'b1;
                aw_addr_q <= awaddr;
            end
            if (wvalid && wready) begin
                w_held_q  <= 1'b1;
                w_data_q  <= wdata[7:0];
                w_strb0_q <= wstrb[0];
            end
            if (wr_commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= (aw_is_tx || aw_is_sts) ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_q && bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (arvalid && arready) begin
            rvalid_q <= 1'b1;
            if (araddr == TX_OFF) begin
                rdata_q <= '0;
                rresp_q <= RESP_OKAY;
            end else if (araddr == STS_OFF) begin
                rdata_q <= status_word(fifo_full, fifo_empty, tx_idle);
                rresp_q <= RESP_OKAY;
            end else begin
                rdata_q <= '0;
                rresp_q <= RESP_SLVERR;
            end
        end else if (rvalid_q && rready) begin
            rvalid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    assign baud_done = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    shift_d = fifo_rdata;
                    state_d = TX_START;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            TX_START: begin
                if (baud_done) begin
                    state_d = TX_DATA;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            TX_DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = TX_STOP;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            TX_STOP: begin
                if (baud_done) begin
                    state_d = TX_IDLE;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = TX_IDLE;
                baud_d  = '0;
            end
        endcase
    end

    assign sout = (state_q == TX_START) ? 1'b0 :
                  (state_q == TX_DATA)  ? shift_q[0] : 1'b1;

endmodule

// File: tb/tb_axil_uart_tx_responder.sv
// Directed bench for the AXI4-Lite UART transmitter: reset state, frame shape,
// channel ordering, FIFO-full stall, bad offsets, backpressure and mid-frame reset.
module tb_axil_uart_tx_responder;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int AW    = 13;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] awaddr = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b0;
    logic [AW-1:0] araddr = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready = 1'b0;
    logic          sout;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int b_cnt = 0;
    int f_start[$];
    int b_rise[$];
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    axil_uart_tx_responder #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .ADDR_W      (AW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .awaddr (awaddr),
        .awvalid(awvalid),
        .awready(awready),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .wvalid (wvalid),
        .wready (wready),
        .bresp  (bresp),
        .bvalid (bvalid),
        .bready (bready),
        .araddr (araddr),
        .arvalid(arvalid),
        .arready(arready),
        .rdata  (rdata),
        .rresp  (rresp),
        .rvalid (rvalid),
        .rready (rready),
        .sout   (sout)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // B-channel observer: counts handshakes and records the cycle bvalid rises.
    initial begin
        logic prev_hs;
        logic prev_bv;
        prev_hs = 1'b0;
        prev_bv = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (prev_hs) b_cnt++;
            if (bvalid && !prev_bv) b_rise.push_back(cyc);
            prev_hs = bvalid && bready;
            prev_bv = bvalid;
        end
    end

    // Serial line decoder: samples each bit in the middle of its period.
    initial begin
        logic [7:0] b;
        forever begin
            @(posedge clk);
            #2;
            if (!rst && sout === 1'b0) begin
                f_start.push_back(cyc);
                repeat (CPB / 2) begin @(posedge clk); #2; end
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) begin @(posedge clk); #2; end
                    b[i] = sout;
                end
                repeat (CPB) begin @(posedge clk); #2; end
                rx_q.push_back(b);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic axi_wr(input logic [AW-1:0] addr, input logic [7:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, output logic [1:0] resp);
        int  c;
        bit  aw_done, w_done, aw_hs, w_hs, got;
        aw_done = 0; w_done = 0; c = 0; got = 0;
        bready = 1'b1;
        while (!(aw_done && w_done) && c < 200) begin
            if (!aw_done && c >= aw_dly) begin awaddr = addr; awvalid = 1'b1; end
            if (!w_done && c >= w_dly) begin wdata = {24'h0, data}; wstrb = strb; wvalid = 1'b1; end
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            c++;
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin wvalid = 1'b0;  w_done = 1;  end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check_val("wr_accept", 32'(aw_done && w_done), 1);
        resp = 2'b11;
        c = 0;
        while (!got && c < 2000) begin
            if (bvalid) begin resp = bresp; got = 1; end
            tick();
            c++;
        end
        check_val("wr_bvalid_seen", 32'(got), 1);
    endtask

    task automatic push_aw_w(input logic [AW-1:0] addr, input logic [7:0] data,
                             input bit use_aw, input bit use_w, output int done_cyc);
        int c;
        bit aw_done, w_done, aw_hs, w_hs;
        aw_done = !use_aw; w_done = !use_w; c = 0;
        if (use_aw) begin awaddr = addr; awvalid = 1'b1; end
        if (use_w)  begin wdata = {24'h0, data}; wstrb = 4'h1; wvalid = 1'b1; end
        while (!(aw_done && w_done) && c < 200) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            c++;
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin wvalid = 1'b0;  w_done = 1;  end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check_val("aw_w_accept", 32'(aw_done && w_done), 1);
        done_cyc = cyc;
    endtask

    task automatic axi_rd(input logic [AW-1:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int c;
        bit hs;
        c = 0; hs = 0;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        while (!hs && c < 100) begin
            hs = arvalid && arready;
            tick();
            c++;
        end
        arvalid = 1'b0;
        c = 0;
        while (!rvalid && c < 100) begin tick(); c++; end
        check_val("rd_rvalid_seen", 32'(rvalid), 1);
        data = rdata;
        resp = rresp;
        tick();
    endtask

    task automatic wait_rx(input int n, input int budget);
        int c;
        c = 0;
        while (rx_q.size() < n && c < budget) begin tick(); c++; end
        check_val("rx_count", 32'(rx_q.size()), 32'(n));
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic [9:0]  frame;
        logic [7:0]  burst [18];
        logic [7:0]  exp3 [3];
        int          hs_cyc [18];
        int          nf, nb, nr, nbc, t, gap, st;

        repeat (3) tick();
        check_val("rst_sout", 32'(sout), 1);
        check_val("rst_bvalid", 32'(bvalid), 0);
        check_val("rst_rvalid", 32'(rvalid), 0);
        check_val("rst_awready", 32'(awready), 1);
        check_val("rst_wready", 32'(wready), 1);
        check_val("rst_arready", 32'(arready), 1);
        check_val("rst_bresp", 32'(bresp), 0);
        check_val("rst_rresp", 32'(rresp), 0);
        check_val("rst_rdata", rdata, 0);
        rst = 1'b0;
        tick();
        axi_rd(13'h1004, d, r);
        check_val("rst_status", d, 32'h6);
        check_val("rst_status_resp", 32'(r), 0);

        // single byte 0x41, exact line waveform
        axi_wr(13'h1000, 8'h41, 4'h1, 0, 0, r);
        check_val("tx41_bresp", 32'(r), 0);
        t = 0;
        while (sout !== 1'b0 && t < 20) begin tick(); t++; end
        frame = {1'b1, 8'h41, 1'b0};
        for (int bi = 0; bi < 10; bi++) begin
            for (int k = 0; k < CPB; k++) begin
                check_val("tx41_line", 32'(sout), 32'(frame[bi]));
                tick();
            end
        end
        repeat (2) tick();
        axi_rd(13'h1004, d, r);
        check_val("tx41_status_after", d, 32'h6);
        wait_rx(1, 100);
        check_val("tx41_rx", 32'(rx_q[0]), 32'h41);

        // channel ordering: W first, AW first, same cycle
        nr = rx_q.size();
        exp3[0] = 8'h11; exp3[1] = 8'h22; exp3[2] = 8'h33;
        nb = b_cnt;
        axi_wr(13'h1000, exp3[0], 4'h1, 5, 0, r);
        repeat (2) tick();
        check_val("order_w_first_b", 32'(b_cnt), 32'(nb + 1));
        check_val("order_w_first_resp", 32'(r), 0);
        axi_wr(13'h1000, exp3[1], 4'h1, 0, 3, r);
        repeat (2) tick();
        check_val("order_aw_first_b", 32'(b_cnt), 32'(nb + 2));
        axi_wr(13'h1000, exp3[2], 4'h1, 0, 0, r);
        repeat (5) tick();
        check_val("order_same_b", 32'(b_cnt), 32'(nb + 3));
        wait_rx(nr + 3, 400);
        for (int i = 0; i < 3; i++) check_val("order_rx", 32'(rx_q[nr + i]), 32'(exp3[i]));
        repeat (5) tick();

        // FIFO full: one frame in flight plus 17 queued bytes; the last must stall
        burst[0] = 8'hEE;
        for (int i = 1; i < 18; i++) burst[i] = 8'(i - 1);
        nf = f_start.size(); nb = b_rise.size(); nbc = b_cnt; nr = rx_q.size();
        bready = 1'b1;
        for (int i = 0; i < 18; i++) push_aw_w(13'h1000, burst[i], 1, 1, hs_cyc[i]);
        t = 0;
        while (b_cnt < nbc + 18 && t < 300) begin tick(); t++; end
        check_val("full_b_count", 32'(b_cnt), 32'(nbc + 18));
        check_val("full_brise_count", 32'(b_rise.size()), 32'(nb + 18));
        if (b_rise.size() >= nb + 18 && f_start.size() >= nf + 2) begin
            gap = b_rise[nb + 17] - hs_cyc[17];
            check_val("full_17th_stalls", 32'(gap > 4), 1);
            gap = b_rise[nb + 17] - f_start[nf + 1];
            check_val("full_b_after_pop", 32'(gap >= 0 && gap <= 1), 1);
        end
        wait_rx(nr + 18, 18 * 45 + 100);
        for (int i = 0; i < 18; i++) check_val("full_rx_order", 32'(rx_q[nr + i]), 32'(burst[i]));
        repeat (5) tick();

        // bad offset, strobe-less TX write, reads of non-readable offsets
        nf = f_start.size();
        axi_wr(13'h1008, 8'h77, 4'h1, 0, 0, r);
        check_val("bad_wr_resp", 32'(r), 32'h2);
        axi_wr(13'h1000, 8'h66, 4'h0, 0, 0, r);
        check_val("nostrb_wr_resp", 32'(r), 0);
        repeat (5) tick();
        axi_rd(13'h1004, d, r);
        check_val("bad_wr_no_push", d, 32'h6);
        axi_rd(13'h1008, d, r);
        check_val("bad_rd_data", d, 0);
        check_val("bad_rd_resp", 32'(r), 32'h2);
        axi_rd(13'h1000, d, r);
        check_val("txdata_rd_data", d, 0);
        check_val("txdata_rd_resp", 32'(r), 0);
        check_val("bad_wr_no_frame", 32'(f_start.size()), 32'(nf));

        // B backpressure, then reset in the middle of data bit 3
        nf = f_start.size(); nb = b_cnt; nr = rx_q.size();
        bready = 1'b0;
        push_aw_w(13'h1000, 8'h55, 1, 1, t);
        t = 0;
        while (!bvalid && t < 20) begin tick(); t++; end
        for (int i = 0; i < 10; i++) begin
            check_val("bp_bvalid_hold", 32'(bvalid), 1);
            check_val("bp_bresp_hold", 32'(bresp), 0);
            tick();
        end
        push_aw_w(13'h1000, 8'h00, 1, 0, t);
        for (int i = 0; i < 3; i++) begin
            check_val("bp_awready_low", 32'(awready), 0);
            tick();
        end
        push_aw_w(13'h1000, 8'hA3, 0, 1, t);
        bready = 1'b1;
        t = 0;
        while (b_cnt < nb + 2 && t < 50) begin tick(); t++; end
        check_val("bp_b_count", 32'(b_cnt), 32'(nb + 2));
        axi_wr(13'h1000, 8'h3C, 4'h1, 0, 0, r);
        t = 0;
        while (f_start.size() < nf + 2 && t < 200) begin tick(); t++; end
        check_val("mid_frame_started", 32'(f_start.size()), 32'(nf + 2));
        st = (f_start.size() >= nf + 2) ? f_start[nf + 1] : cyc;
        t = 0;
        while (cyc < st + 17 && t < 100) begin tick(); t++; end
        check_val("mid_bit3_level", 32'(sout), 0);
        rst = 1'b1;
        tick();
        check_val("mid_rst_sout", 32'(sout), 1);
        check_val("mid_rst_bvalid", 32'(bvalid), 0);
        rst = 1'b0;
        tick();
        axi_rd(13'h1004, d, r);
        check_val("mid_rst_status", d, 32'h6);
        repeat (60) tick();
        check_val("mid_rst_no_frame", 32'(f_start.size()), 32'(nf + 2));
        check_val("bp_rx_first", 32'(rx_q[nr]), 32'h55);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
